// File: rtl/mux161_arb_pkg.sv
// Shared types and constants for the round-robin 16:1 mux select arbiter.
package mux161_arb_pkg;

  localparam int unsigned N_REQ_DEF = 16;
  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned HOLD_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux161_rr_arbiter_rr_pick.sv
// Circular priority search: first requester at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N_REQ = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = |req;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux161_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux with a held grant.
// Optional hold-timeout preemption is enabled by defining MUX161_ARB_TIMEOUT_EN.
import mux161_arb_pkg::*;

module mux161_rr_arbiter #(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned SEL_W    = SEL_W_DEF,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             preempt
);

  if (N_REQ < 2 || N_REQ > 16 || N_REQ != (32'(1) << SEL_W)) begin : g_bad_n_req
    $error("mux161_rr_arbiter: N_REQ must be a power of two in 2..16 equal to 2**SEL_W");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux161_rr_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_e       state_q, state_n;
  logic [SEL_W-1:0] ptr_q, ptr_n;
  logic [N_REQ-1:0] gnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             busy_n;
  logic             found;
  logic [SEL_W-1:0] idx;

  rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (idx)
  );

`ifdef MUX161_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_n, hold_sat;
  logic              preempt_n;
  logic              others;

  assign hold_sat = (hold_q >= HOLD_LIM) ? HOLD_LIM : hold_q + HOLD_W'(1);
  assign others   = |(req & ~gnt);
`else
  assign preempt = 1'b0;
`endif

  // Next-state and next-output logic; GAP re-arbitrates exactly like IDLE.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    gnt_n   = gnt;
    sel_n   = sel;
    busy_n  = busy;
`ifdef MUX161_ARB_TIMEOUT_EN
    hold_n    = hold_q;
    preempt_n = 1'b0;
`endif
    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          sel_n   = idx;
          gnt_n   = N_REQ'(1) << idx;
          busy_n  = 1'b1;
          state_n = BUSY;
`ifdef MUX161_ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end else begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (!req[sel]) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = sel + SEL_W'(1);
          state_n = GAP;
        end
`ifdef MUX161_ARB_TIMEOUT_EN
        else if (hold_sat >= HOLD_LIM && others) begin
          gnt_n     = '0;
          busy_n    = 1'b0;
          ptr_n     = sel + SEL_W'(1);
          preempt_n = 1'b1;
          state_n   = GAP;
        end else begin
          hold_n = hold_sat;
        end
`endif
      end
      default: begin
        gnt_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
`ifdef MUX161_ARB_TIMEOUT_EN
      hold_q  <= '0;
      preempt <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      gnt     <= gnt_n;
      sel     <= sel_n;
      busy    <= busy_n;
`ifdef MUX161_ARB_TIMEOUT_EN
      hold_q  <= hold_n;
      preempt <= preempt_n;
`endif
    end
  end

endmodule

// File: tb/tb_mux161_rr_arbiter.sv
// Self-checking bench for mux161_rr_arbiter against a behavioural owner/pointer model.
module tb_mux161_rr_arbiter;

  localparam int N = 16;
`ifdef MUX161_ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
  localparam bit TO_EN    = 1'b1;
`else
  localparam int MAX_HOLD = 8;
  localparam bit TO_EN    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        busy;
  logic        preempt;

  int checks = 0;
  int errors = 0;

  // Model: current owner (-1 = none), rotating pointer, hold count, last select.
  int       m_owner;
  int       m_ptr;
  int       m_hold;
  logic [3:0] m_sel;
  logic     m_pre;

  always #5 clk = ~clk;

  mux161_rr_arbiter #(.N_REQ(16), .SEL_W(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_gnt();
    return (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0000;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 4'd0;
    m_pre   = 1'b0;
  endtask

  // One clock edge of the arbitration rules; a release leaves one ownerless cycle.
  task automatic model_step(input logic [15:0] r);
    int j;
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (TO_EN && (m_hold + 1 >= MAX_HOLD) && ((r & ~m_gnt()) != 16'h0000)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_pre   = 1'b1;
      end else begin
        m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
      end
    end else begin
      j = pick(r, m_ptr);
      if (j >= 0) begin
        m_owner = j;
        m_sel   = 4'(j);
        m_hold  = 0;
      end
    end
  endtask

  task automatic cycle(input logic [15:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 16'hFFFF;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL reset_gnt: got %h expected 0000", gnt); end
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b expected 0", preempt); end
    rst_n = 1'b1;
    @(posedge clk);
    model_step(16'hFFFF);
    #1;
    checks++; if (gnt !== 16'h0001 || sel !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant: got gnt=%h sel=%0d busy=%b expected gnt=0001 sel=0 busy=1", gnt, sel, busy);
    end
  endtask

  task automatic test_rotation();
    logic [15:0] rq [7];
    logic [15:0] eg [7];
    int          es [7];
    rq = '{16'h0011, 16'h0011, 16'h0011, 16'h0010, 16'h0010, 16'h0001, 16'h0001};
    eg = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0010, 16'h0000, 16'h0001};
    es = '{0, 0, 0, 0, 4, 4, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(rq[i]);
      checks++; if (gnt !== eg[i] || sel !== 4'(es[i]) || busy !== (eg[i] != 16'h0000)) begin
        errors++; $display("FAIL rotation step %0d: got gnt=%h sel=%0d busy=%b expected gnt=%h sel=%0d", i, gnt, sel, busy, eg[i], es[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] rq [4];
    logic [15:0] eg [4];
    int          es [4];
    rq = '{16'h8000, 16'h8004, 16'h0004, 16'h0004};
    eg = '{16'h8000, 16'h8000, 16'h0000, 16'h0004};
    es = '{15, 15, 15, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(rq[i]);
      checks++; if (gnt !== eg[i] || sel !== 4'(es[i]) || busy !== (eg[i] != 16'h0000)) begin
        errors++; $display("FAIL wrap step %0d: got gnt=%h sel=%0d busy=%b expected gnt=%h sel=%0d", i, gnt, sel, busy, eg[i], es[i]);
      end
    end
  endtask

  task automatic test_stability();
    logic [15:0] r;
    do_reset();
    cycle(16'h0080);
    checks++; if (gnt !== 16'h0080 || sel !== 4'd7) begin
      errors++; $display("FAIL stability_grant: got gnt=%h sel=%0d expected gnt=0080 sel=7", gnt, sel);
    end
    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom) | 16'h0080;
      cycle(r);
      checks++; if (gnt !== m_gnt() || sel !== m_sel || busy !== (m_owner >= 0) || preempt !== m_pre) begin
        errors++; $display("FAIL stability cyc %0d: got gnt=%h sel=%0d pre=%b expected gnt=%h sel=%0d pre=%b", i, gnt, sel, preempt, m_gnt(), m_sel, m_pre);
      end
    end
  endtask

  task automatic test_idle_hold();
    logic [15:0] rq [4];
    logic [15:0] eg [4];
    int          es [4];
    rq = '{16'h0200, 16'h0000, 16'h0000, 16'h0020};
    eg = '{16'h0200, 16'h0000, 16'h0000, 16'h0020};
    es = '{9, 9, 9, 5};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(rq[i]);
      checks++; if (gnt !== eg[i] || sel !== 4'(es[i]) || busy !== (eg[i] != 16'h0000)) begin
        errors++; $display("FAIL idle_hold step %0d: got gnt=%h sel=%0d busy=%b expected gnt=%h sel=%0d", i, gnt, sel, busy, eg[i], es[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 16'h0000 || busy !== 1'b0 || sel !== 4'd0) begin
      errors++; $display("FAIL async_reset: got gnt=%h busy=%b sel=%0d expected gnt=0000 busy=0 sel=0", gnt, busy, sel);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    int npre;
    int mpre;
    npre = 0;
    mpre = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(16'h0028);
      npre += int'(preempt === 1'b1);
      mpre += int'(m_pre);
      checks++; if (gnt !== m_gnt() || sel !== m_sel || busy !== (m_owner >= 0) || preempt !== m_pre) begin
        errors++; $display("FAIL timeout_contended cyc %0d: got gnt=%h sel=%0d pre=%b expected gnt=%h sel=%0d pre=%b", i, gnt, sel, preempt, m_gnt(), m_sel, m_pre);
      end
    end
    checks++; if (npre != mpre) begin
      errors++; $display("FAIL timeout_pulse_count: got %0d expected %0d", npre, mpre);
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(16'h0008);
      checks++; if (gnt !== 16'h0008 || sel !== 4'd3 || preempt !== 1'b0) begin
        errors++; $display("FAIL timeout_alone cyc %0d: got gnt=%h sel=%0d pre=%b expected gnt=0008 sel=3 pre=0", i, gnt, sel, preempt);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) r = 16'h0000;
      if (m_owner >= 0 && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
      cycle(r);
      checks++; if (gnt !== m_gnt() || sel !== m_sel || busy !== (m_owner >= 0) || preempt !== m_pre) begin
        errors++; $display("FAIL random cyc %0d req=%h: got gnt=%h sel=%0d busy=%b pre=%b expected gnt=%h sel=%0d busy=%b pre=%b",
                           i, r, gnt, sel, busy, preempt, m_gnt(), m_sel, (m_owner >= 0), m_pre);
      end
      checks++; if ((gnt & (gnt - 16'h0001)) != 16'h0000 || (gnt != 16'h0000 && gnt != (16'(1) << sel)) || busy !== (|gnt)) begin
        errors++; $display("FAIL random_invariant cyc %0d: got gnt=%h sel=%0d busy=%b expected one-hot gnt matching sel", i, gnt, sel, busy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_stability();
    test_idle_hold();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux161_rr_arbiter.md
Name: mux161_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 single-bit select mux between 16 requesters.
- Drives the mux's 4-bit select (MSB..LSB = s1,s2,s3,s4) and a one-hot grant.
- A grant is held until the owner drops its request, so the mux path stays stable for a whole transfer.
- Sits directly upstream of the mux select pins; requesters see their grant and know their data is routed to the mux output.

Parameters:
- N_REQ, 16, number of requesters; power of two, 2..16.
- SEL_W, 4, select width, equal to log2(N_REQ).
- MAX_HOLD, 8, max consecutive cycles one owner may hold the grant while others wait; used only with the optional feature; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  request vector; bit i high means requester i wants the mux.
- gnt  output  N_REQ  one-hot grant, registered; all zero when no owner.
- sel  output  SEL_W  mux select, registered; bit SEL_W-1 drives s1, bit 0 drives s4.
- busy  output  1  high while an owner holds the grant.
- preempt  output  1  one-cycle pulse when a grant is forcibly revoked; tied 0 without the optional feature.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, ptr=0, gnt=0, sel=0, busy=0, preempt=0, hold counter=0.
- States: IDLE, BUSY, GAP.
- Pick rule: the first index j with req[j]=1, searching circularly from ptr upward (ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1).
- IDLE:
  - If req is non-zero, apply the pick rule, then register sel=j, gnt=1<<j, busy=1, and go to BUSY.
  - Latency is 1: req sampled at edge k gives gnt at edge k.
  - If req is zero, stay in IDLE; sel keeps its last value (no glitch on the mux); gnt=0.
- BUSY:
  - While req[sel]=1, hold sel, gnt and busy unchanged. Other requests are ignored.
  - When req[sel]=0 is sampled: gnt=0, busy=0, ptr=(sel+1) mod N_REQ, go to GAP.
  - Wrap case: sel=15 sets ptr=0.
- GAP:
  - Exactly one bubble cycle with no grant, so the mux output settles between owners.
  - At the next edge apply the IDLE rules: grant if req is non-zero, otherwise go to IDLE.
- Minimum spacing between two grants is one dead cycle.
- A request is not required to stay high while waiting; a requester that drops before being granted is simply skipped.
- ptr updates only on a release or a preemption, never in IDLE.
- Invariants: gnt is always zero or one-hot; when gnt is non-zero, gnt==1<<sel; busy==|gnt.
- Reset asserted mid-grant drops gnt and busy immediately (asynchronous) and returns to IDLE with ptr=0.
- With N_REQ<16, only the low SEL_W select bits exist; the unused mux inputs are never selected.

Optional Feature:
- Macro: MUX161_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD while req[sel] is still 1, and at least one other req bit is set, the grant is revoked: gnt=0, busy=0, ptr=sel+1, preempt=1 for one cycle, go to GAP.
  - If no other requester is waiting, the counter saturates at MAX_HOLD and the grant continues.
- Undefined: no counter; a grant persists until released; preempt is constant 0.

Decomposition:
- Package mux161_arb_pkg holds:
  - the state enum (IDLE=2'd0, BUSY=2'd1, GAP=2'd2);
  - N_REQ_DEF=16 and SEL_W_DEF=4;
  - the hold-counter width constant HOLD_W=8.
- One combinational sub-module, rr_pick:
  - inputs req and ptr; outputs found and idx;
  - implements the circular priority search.
- Registers and the FSM live in the top module.

Test Plan:
- Reset: hold rst_n=0 with req=16'hFFFF -> gnt=0, sel=0, busy=0. Release reset -> at the next edge gnt=16'h0001, sel=0.
- Round-robin rotation: req=16'h0011 held; owner 0 drops after 3 cycles -> one gap cycle, then gnt=16'h0010, sel=4. Owner 4 drops -> gap, then gnt=16'h0001.
- Wrap: only req[15] and req[2] active, current owner 15 releases -> ptr=0, next grant sel=2 after one gap cycle.
- Stability: owner 7 granted; toggle all other req bits randomly for 20 cycles -> sel stays 7 and gnt stays 16'h0080 throughout.
- Idle hold: owner 9 releases and req=0 -> gnt=0, busy=0, sel stays 9. Assert rst_n=0 mid-grant -> gnt=0 in the same cycle, with no clock edge needed.
- Timeout (macro defined, MAX_HOLD=4): req[3] and req[5] both held high -> owner 3 is revoked after 4 BUSY cycles with preempt=1 pulsed, gap, then sel=5. Same test with only req[3] high -> no preemption.
